inst_fetch: RTL and testbench

//   Instruction fetch unit: the producer side of the decode interface. Owns the PC, issues word reads
//   to instruction memory, presents {inst_o, pc_o} to the decoder under a valid/ready handshake.

---
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fetch.sv | 174 +++++++++++++++++
 tb/tb_inst_fetch.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handshake and PC redirect.
// master = fetch unit, slave = memory/decode/execute side.
interface inst_fetch_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] pc_o;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;

    modport master (
        output imem_req_valid_o, imem_addr_o, inst_valid_o, inst_o, pc_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  inst_ready_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_valid_o, imem_addr_o, inst_valid_o, inst_o, pc_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output inst_ready_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, one outstanding imem read, valid/ready hand-off to decode.
// Optional IFU_MISALIGN_CHK_EN adds fetch_fault_o and a sticky S_FAULT state for misaligned redirects.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk_i,
    input  logic          rst_i,
    inst_fetch_if.master  bus
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic          fetch_fault_o
`endif
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
`ifdef IFU_MISALIGN_CHK_EN
        ,
        S_FAULT
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              inst_valid_q, inst_valid_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   pc_o_q, pc_o_d;
    logic [XLEN-1:0]   redirect_tgt;
    logic              outstanding;
`ifdef IFU_MISALIGN_CHK_EN
    logic              fault_q, fault_d;
    logic              fault_pend_q, fault_pend_d;
    logic              misalign;

    assign redirect_tgt = bus.redirect_pc_i;
    assign misalign     = |bus.redirect_pc_i[1:0];
`else
    logic              redirect_lsb_unused;

    // Low address bits are dropped: fetch is always word aligned.
    assign redirect_tgt        = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused = ^bus.redirect_pc_i[1:0];
`endif

    // Next-state and next-output logic; redirect overrides whatever the state did.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        pc_o_d       = pc_o_q;
        outstanding  = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        fault_d      = fault_q;
        fault_pend_d = fault_pend_q;
`endif

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.imem_req_ready_i) begin
                    state_d     = S_WAIT;
                    outstanding = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid_i) begin
                    inst_d       = bus.imem_rsp_data_i;
                    pc_o_d       = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + XLEN'(4);
                    state_d      = S_HOLD;
                end else begin
                    outstanding = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.inst_ready_i) begin
                    inst_valid_d = 1'b0;
                    inst_d       = NOP_INST;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                if (bus.imem_rsp_valid_i) begin
                    state_d = S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
                    if (fault_pend_q) begin
                        state_d      = S_FAULT;
                        fault_d      = 1'b1;
                        fault_pend_d = 1'b0;
                        pc_o_d       = pc_q;
                    end
`endif
                end else begin
                    outstanding = 1'b1;
                end
            end
`ifdef IFU_MISALIGN_CHK_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_IDLE;
        endcase

        // A response still in flight must be drained before the next request.
        if (bus.redirect_i) begin
            pc_d         = redirect_tgt;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            state_d      = outstanding ? S_DROP : S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
            fault_d      = 1'b0;
            fault_pend_d = 1'b0;
            if (misalign) begin
                if (outstanding) begin
                    fault_pend_d = 1'b1;
                end else begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    pc_o_d  = redirect_tgt;
                end
            end
`endif
        end

        req_valid_d = (state_d == S_REQ);
        addr_d      = pc_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_valid_q  <= 1'b0;
            addr_q       <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            pc_o_q       <= RESET_PC;
`ifdef IFU_MISALIGN_CHK_EN
            fault_q      <= 1'b0;
            fault_pend_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            addr_q       <= addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            pc_o_q       <= pc_o_d;
`ifdef IFU_MISALIGN_CHK_EN
            fault_q      <= fault_d;
            fault_pend_q <= fault_pend_d;
`endif
        end
    end

    assign bus.imem_req_valid_o = req_valid_q;
    assign bus.imem_addr_o      = addr_q;
    assign bus.inst_valid_o     = inst_valid_q;
    assign bus.inst_o           = inst_q;
    assign bus.pc_o             = pc_o_q;
`ifdef IFU_MISALIGN_CHK_EN
    assign fetch_fault_o        = fault_q;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: drives imem/decode/redirect by hand and checks against hand-computed values.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst;
    logic fault;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rsp_outstanding;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .fetch_fault_o (fault)
`endif
    );

`ifndef IFU_MISALIGN_CHK_EN
    assign fault = 1'b0;
`endif

    always #5 clk = ~clk;

    // Memory-side protocol monitor: responses only while one is owed; no request while one is owed.
    always @(posedge clk) begin
        if (rst) begin
            rsp_outstanding <= 1'b0;
        end else begin
            assert (!bus.imem_rsp_valid_i || rsp_outstanding)
                else $error("protocol: imem response with nothing outstanding");
            assert (!(bus.imem_req_valid_o && rsp_outstanding))
                else $error("protocol: request issued while response outstanding");
            if (bus.imem_rsp_valid_i)
                rsp_outstanding <= 1'b0;
            else if (bus.imem_req_valid_o && bus.imem_req_ready_i)
                rsp_outstanding <= 1'b1;
        end
    end

    task automatic test_reset;
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid_o); end
        n_checks++; if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", bus.inst_valid_o); end
        n_checks++; if (bus.inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h want 00000013", bus.inst_o); end
        n_checks++; if (bus.pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h want 80000000", bus.pc_o); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch;
        @(negedge clk);
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b want 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL first_req_addr: got %h want 80000000", bus.imem_addr_o); end
        bus.imem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.imem_req_ready_i = 1'b0;
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL first_wait_req: got %b want 0", bus.imem_req_valid_o); end
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'h0000_0013;
        @(negedge clk);
        bus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (bus.inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL first_inst_valid: got %b want 1", bus.inst_valid_o); end
        n_checks++; if (bus.inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL first_inst: got %h want 00000013", bus.inst_o); end
        n_checks++; if (bus.pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL first_pc: got %h want 80000000", bus.pc_o); end
        bus.inst_ready_i = 1'b1;
        @(negedge clk);
        bus.inst_ready_i = 1'b0;
        n_checks++; if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL first_consumed: got %b want 0", bus.inst_valid_o); end
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL second_req_valid: got %b want 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0004) begin n_fail++; $display("FAIL second_req_addr: got %h want 80000004", bus.imem_addr_o); end
    endtask

    task automatic test_req_stall;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_req_valid[%0d]: got %b want 1", i, bus.imem_req_valid_o); end
            n_checks++; if (bus.imem_addr_o !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_req_addr[%0d]: got %h want 80000004", i, bus.imem_addr_o); end
            if (i < 4) @(negedge clk);
        end
        bus.imem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.imem_req_ready_i = 1'b0;
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_accepted: got %b want 0", bus.imem_req_valid_o); end
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'h0010_0093;
        @(negedge clk);
        bus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (bus.inst_o !== 32'h0010_0093) begin n_fail++; $display("FAIL stall_inst: got %h want 00100093", bus.inst_o); end
        n_checks++; if (bus.pc_o !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_pc: got %h want 80000004", bus.pc_o); end
    endtask

    task automatic test_hold_stall;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.inst_valid_o); end
            n_checks++; if (bus.inst_o !== 32'h0010_0093) begin n_fail++; $display("FAIL hold_inst[%0d]: got %h want 00100093", i, bus.inst_o); end
            n_checks++; if (bus.pc_o !== 32'h8000_0004) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h want 80000004", i, bus.pc_o); end
            n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_no_req[%0d]: got %b want 0", i, bus.imem_req_valid_o); end
            @(negedge clk);
        end
        bus.inst_ready_i = 1'b1;
        @(negedge clk);
        bus.inst_ready_i = 1'b0;
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0008) begin n_fail++; $display("FAIL hold_next_addr: got %h want 80000008", bus.imem_addr_o); end
    endtask

    task automatic test_redirect_wait;
        bus.imem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.imem_req_ready_i = 1'b0;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0100;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_no_req: got %b want 0", bus.imem_req_valid_o); end
        n_checks++; if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_no_inst: got %b want 0", bus.inst_valid_o); end
        repeat (2) @(negedge clk);
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_still_waiting: got %b want 0", bus.imem_req_valid_o); end
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL stale_valid: got %b want 0", bus.inst_valid_o); end
        n_checks++; if (bus.inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL stale_inst: got %h want 00000013", bus.inst_o); end
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL redir_req_valid: got %b want 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0100) begin n_fail++; $display("FAIL redir_req_addr: got %h want 80000100", bus.imem_addr_o); end
    endtask

    task automatic test_redirect_coincident;
        bus.imem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'hBADC_0DE0;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0200;
        @(negedge clk);
        bus.imem_rsp_valid_i = 1'b0; bus.redirect_i = 1'b0;
        n_checks++; if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL co_rsp_valid: got %b want 0", bus.inst_valid_o); end
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL co_rsp_req: got %b want 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0200) begin n_fail++; $display("FAIL co_rsp_addr: got %h want 80000200", bus.imem_addr_o); end
        bus.imem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'h1111_1111;
        @(negedge clk);
        bus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (bus.inst_o !== 32'h1111_1111) begin n_fail++; $display("FAIL co_fetch_inst: got %h want 11111111", bus.inst_o); end
        n_checks++; if (bus.pc_o !== 32'h8000_0200) begin n_fail++; $display("FAIL co_fetch_pc: got %h want 80000200", bus.pc_o); end
        bus.inst_ready_i = 1'b1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0300;
        @(negedge clk);
        bus.inst_ready_i = 1'b0; bus.redirect_i = 1'b0;
        n_checks++; if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL co_hold_valid: got %b want 0", bus.inst_valid_o); end
        n_checks++; if (bus.inst_o !== 32'h0000_0013) begin n_fail++; $display("FAIL co_hold_inst: got %h want 00000013", bus.inst_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0300) begin n_fail++; $display("FAIL co_hold_addr: got %h want 80000300", bus.imem_addr_o); end
    endtask

    task automatic test_misalign;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0102;
        @(negedge clk);
        bus.redirect_i = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b want 1", fault); end
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_no_req: got %b want 0", bus.imem_req_valid_o); end
        n_checks++; if (bus.pc_o !== 32'h8000_0102) begin n_fail++; $display("FAIL mis_pc: got %h want 80000102", bus.pc_o); end
        @(negedge clk);
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %b want 1", fault); end
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_sticky_req: got %b want 0", bus.imem_req_valid_o); end
`else
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL mis_req_valid: got %b want 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0100) begin n_fail++; $display("FAIL mis_forced_addr: got %h want 80000100", bus.imem_addr_o); end
`endif
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0200;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL mis_cleared: got %b want 0", fault); end
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL mis_resume_req: got %b want 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0200) begin n_fail++; $display("FAIL mis_resume_addr: got %h want 80000200", bus.imem_addr_o); end
    endtask

    task automatic test_pc_wrap;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        n_checks++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req_addr: got %h want fffffffc", bus.imem_addr_o); end
        bus.imem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'h0000_0073;
        @(negedge clk);
        bus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (bus.pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want fffffffc", bus.pc_o); end
        n_checks++; if (bus.inst_o !== 32'h0000_0073) begin n_fail++; $display("FAIL wrap_inst: got %h want 00000073", bus.inst_o); end
        bus.inst_ready_i = 1'b1;
        @(negedge clk);
        bus.inst_ready_i = 1'b0;
        n_checks++; if (bus.imem_addr_o !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 00000000", bus.imem_addr_o); end
    endtask

    task automatic test_redirect_on_accept;
        bus.imem_req_ready_i = 1'b1;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8000_0400;
        @(negedge clk);
        bus.imem_req_ready_i = 1'b0; bus.redirect_i = 1'b0;
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL acc_drop_req: got %b want 0", bus.imem_req_valid_o); end
        @(negedge clk);
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL acc_drop_wait: got %b want 0", bus.imem_req_valid_o); end
        bus.imem_rsp_valid_i = 1'b1; bus.imem_rsp_data_i = 32'h2222_2222;
        @(negedge clk);
        bus.imem_rsp_valid_i = 1'b0;
        n_checks++; if (bus.inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL acc_stale_valid: got %b want 0", bus.inst_valid_o); end
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL acc_req_valid: got %b want 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0400) begin n_fail++; $display("FAIL acc_req_addr: got %h want 80000400", bus.imem_addr_o); end
    endtask

    task automatic test_reset_mid;
        bus.imem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.imem_req_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got %b want 0", bus.imem_req_valid_o); end
        n_checks++; if (bus.pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL mid_rst_pc: got %h want 80000000", bus.pc_o); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.imem_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_restart: got %b want 1", bus.imem_req_valid_o); end
        n_checks++; if (bus.imem_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL mid_rst_addr: got %h want 80000000", bus.imem_addr_o); end
    endtask

    initial begin
        rst                  = 1'b1;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = 32'h0;
        bus.inst_ready_i     = 1'b0;
        bus.redirect_i       = 1'b0;
        bus.redirect_pc_i    = 32'h0;
        repeat (2) @(negedge clk);

        test_reset;
        test_first_fetch;
        test_req_stall;
        test_hold_stall;
        test_redirect_wait;
        test_redirect_coincident;
        test_misalign;
        test_pc_wrap;
        test_redirect_on_accept;
        test_reset_mid;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
